// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Serialises the fetch path and the data path (LW/SW) onto one single-port
// memory. Each access runs IDLE -> ACCESS (WAIT_CYCLES+1 cycles) -> DONE. The
// memory strobe is asserted for one cycle. Read data is captured into the
// owner's register, and the owner gets a one-cycle acknowledge. Data wins a
// tie until STARVE_MAX data grants have been made back to back while fetch
// waited; fetch then wins.
//
// Ports:
//   clk1, rst        clock (posedge), asynchronous active-high reset
//   hold             blocks new grants; an access already in flight completes
//   if_req/if_addr   fetch request and address, held until if_ack
//   if_rdata/if_ack  fetched word (registered) and completion pulse
//   dm_req/dm_we/dm_addr/dm_wdata  data request, store flag, address, store data
//   dm_rdata/dm_ack  loaded word (registered) and completion pulse
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata  memory array port
//   busy             high whenever the arbiter is not idle
//   owner            current or last grant (0 = fetch, 1 = data)
module mem_port_arbiter #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned STARVE_MAX  = 4
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              hold,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] L_WAIT   = 4'(WAIT_CYCLES);
  localparam logic [3:0] L_STARVE = 4'(STARVE_MAX);

  state_t     r_state;
  logic [3:0] r_wait;
  logic [3:0] r_starve;
  logic       r_store;

  logic       w_grant;
  logic       w_data_win;

  assign w_grant    = !hold && (if_req || dm_req);
  // Data wins a tie unless fetch has already waited through STARVE_MAX data grants.
  assign w_data_win = dm_req && !(if_req && (r_starve == L_STARVE));

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_wait    <= '0;
      r_starve  <= '0;
      r_store   <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      if_ack    <= 1'b0;
      dm_ack    <= 1'b0;
      busy      <= 1'b0;
      owner     <= 1'b0;
    end else begin
      // Strobes and acknowledges are single-cycle pulses.
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_state <= ACCESS;
            r_wait  <= '0;
            busy    <= 1'b1;
            mem_en  <= 1'b1;
            if (w_data_win) begin
              owner     <= 1'b1;
              mem_we    <= dm_we;
              r_store   <= dm_we;
              mem_addr  <= dm_addr;
              mem_wdata <= dm_wdata;
              if (if_req && (r_starve != L_STARVE))
                r_starve <= r_starve + 4'd1;
            end else begin
              owner    <= 1'b0;
              r_store  <= 1'b0;
              mem_addr <= if_addr;
              r_starve <= '0;
            end
          end
        end
        ACCESS: begin
          r_wait <= r_wait + 4'd1;
          if (r_wait == L_WAIT) begin
            r_state <= DONE;
            if (owner) begin
              dm_ack <= 1'b1;
              // Stores leave the load register untouched.
              if (!r_store)
                dm_rdata <= mem_rdata;
            end else begin
              if_ack   <= 1'b1;
              if_rdata <= mem_rdata;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Drives mem_port_arbiter with a behavioural memory that returns valid data
// only after the programmed latency. Covers directed single transactions,
// the tie/store case, starvation, hold, an asynchronous reset during an access,
// and a randomised run checked against a timeline model.
module tb_mem_port_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int W  = 3;
  localparam int SM = 4;

  logic          clk1 = 1'b0;
  logic          rst;
  logic          hold;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ack;
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_rdata;
  logic          dm_ack;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;
  logic          owner;

  always #5 clk1 = ~clk1;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(W), .STARVE_MAX(SM)
  ) dut (
    .clk1(clk1), .rst(rst), .hold(hold),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  // Initial memory image; the handful of fixed words anchor the directed tests.
  function automatic logic [31:0] init_word(input logic [9:0] a);
    case (a)
      10'd0:   return 32'hFFFFFFFF;
      10'd5:   return 32'hDEADBEEF;
      10'h010: return 32'h0BADF00D;
      default: return {6'h2A, a, 6'h15, a};
    endcase
  endfunction

  // Memory: samples mem_en on an edge; read data becomes valid W-1 edges later.
  bit [31:0] wmem   [1024];
  bit        wvalid [1024];
  int        lat = -1;

  always @(posedge clk1) begin
    if (mem_en) begin
      lat <= 0;
      if (mem_we) begin
        wmem[mem_addr]   <= mem_wdata;
        wvalid[mem_addr] <= 1'b1;
      end
    end else if (lat >= 0) begin
      lat <= lat + 1;
    end
  end

  assign mem_rdata = (lat >= W - 1 && !mem_en)
                     ? (wvalid[mem_addr] ? wmem[mem_addr] : init_word(mem_addr))
                     : 32'hBAD0BAD0;

  int both_ack = 0;
  always @(negedge clk1) if (if_ack && dm_ack) both_ack <= both_ack + 1;

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] want);
    total_cnt++;
    if (act === want) pass_cnt++;
    else $display("FAIL %s: got %0h want %0h", nm, act, want);
  endtask

  task automatic idle_inputs();
    hold = 1'b0; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0;
  endtask

  task automatic do_reset();
    @(negedge clk1);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk1);
    rst = 1'b0;
  endtask

  // kind 0: wait for mem_en, kind 1: wait for either ack. n = negedges waited.
  task automatic wait_for(input int kind, input int limit, output int n);
    logic s;
    n = 0;
    do begin
      @(negedge clk1);
      n++;
      s = (kind == 0) ? mem_en : (if_ack | dm_ack);
    end while (!s && n < limit);
    check(kind == 0 ? "grant_seen" : "ack_seen", s, 1'b1);
  endtask

  typedef struct {
    logic        ir, dr, we;
    logic [9:0]  ia, da;
    logic [31:0] wd;
    logic        e_owner, e_we;
    logic [9:0]  e_addr;
    logic [31:0] e_rd;
  } vec_t;

  vec_t        tbl [6];
  logic [0:9]  exp_own = 10'b1111011110;
  int          n, gap, cnt;

  // Timeline reference for the random run.
  int          cyc, g, free_edge, starve;
  logic        who, gwe, dwin, seen_if, seen_dm;
  logic [9:0]  gaddr;
  logic [31:0] gwdata, exp_if, exp_dm;
  logic [31:0] ref_mem [64];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk1);
    check("reset_outputs", {if_rdata, dm_rdata, if_ack, dm_ack, mem_en, mem_we,
                            mem_addr, mem_wdata, busy, owner}, '0);
    rst = 1'b0;

    // ---------------- table-driven single transactions ----------------
    tbl[0] = '{1'b1, 1'b0, 1'b0, 10'd5,   10'd0,   32'h0,        1'b0, 1'b0, 10'd5,   32'hDEADBEEF};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 10'd0,   10'h010, 32'h0,        1'b1, 1'b0, 10'h010, 32'h0BADF00D};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 10'd0,   10'h3FF, 32'h12345678, 1'b1, 1'b1, 10'h3FF, 32'h0BADF00D};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 10'd0,   10'h3FF, 32'h0,        1'b1, 1'b0, 10'h3FF, 32'h12345678};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 10'd0,   10'd0,   32'h0,        1'b0, 1'b0, 10'd0,   32'hFFFFFFFF};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 10'h3FF, 10'd0,   32'h0,        1'b0, 1'b0, 10'h3FF, 32'h12345678};
    foreach (tbl[i]) begin
      if_req = tbl[i].ir; if_addr = tbl[i].ia;
      dm_req = tbl[i].dr; dm_we = tbl[i].we; dm_addr = tbl[i].da; dm_wdata = tbl[i].wd;
      wait_for(0, 10, n);
      check($sformatf("tbl%0d_grant_lat", i), n, 1);
      check($sformatf("tbl%0d_owner", i), owner, tbl[i].e_owner);
      check($sformatf("tbl%0d_mem_addr", i), mem_addr, tbl[i].e_addr);
      check($sformatf("tbl%0d_mem_we", i), mem_we, tbl[i].e_we);
      if (tbl[i].e_we) check($sformatf("tbl%0d_mem_wdata", i), mem_wdata, tbl[i].wd);
      wait_for(1, 20, n);
      check($sformatf("tbl%0d_ack_lat", i), n, W + 1);
      check($sformatf("tbl%0d_ack_who", i), {if_ack, dm_ack}, tbl[i].e_owner ? 2'b01 : 2'b10);
      check($sformatf("tbl%0d_rdata", i), tbl[i].e_owner ? dm_rdata : if_rdata, tbl[i].e_rd);
      if_req = 1'b0; dm_req = 1'b0;
      @(negedge clk1);
      check($sformatf("tbl%0d_ack_pulse", i), {if_ack, dm_ack}, 2'b00);
      check($sformatf("tbl%0d_idle", i), busy, 1'b0);
    end

    // ---------------- tie, data store first, then fetch ----------------
    do_reset();
    if_req = 1'b1; if_addr = 10'd5;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 10'h3FF; dm_wdata = 32'h12345678;
    wait_for(0, 10, n);
    check("tie_owner", owner, 1'b1);
    check("tie_mem_we", mem_we, 1'b1);
    check("tie_mem_addr", mem_addr, 10'h3FF);
    check("tie_mem_wdata", mem_wdata, 32'h12345678);
    wait_for(1, 20, gap);
    check("tie_store_ack", {if_ack, dm_ack}, 2'b01);
    check("tie_store_rdata", dm_rdata, 32'h0);
    dm_req = 1'b0;
    wait_for(0, 10, n);
    check("tie_fetch_gap", gap + n, W + 3);
    check("tie_fetch_owner", owner, 1'b0);
    check("tie_fetch_addr", mem_addr, 10'd5);
    check("tie_fetch_we", mem_we, 1'b0);
    wait_for(1, 20, n);
    check("tie_fetch_rdata", if_rdata, 32'hDEADBEEF);
    if_req = 1'b0;

    // ---------------- starvation ----------------
    do_reset();
    if_req = 1'b1; if_addr = 10'd5; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'h010;
    for (int k = 0; k < 10; k++) begin
      wait_for(0, 20, n);
      if (k == 0) check("starve_first_lat", n, 1);
      else        check($sformatf("starve_gap%0d", k), n, W + 3);
      check($sformatf("starve_grant%0d", k), owner, exp_own[k]);
    end
    if_req = 1'b0; dm_req = 1'b0;
    repeat (W + 4) @(negedge clk1);

    // ---------------- hold ----------------
    do_reset();
    if_req = 1'b1; if_addr = 10'h010;
    wait_for(0, 10, n);
    check("hold_grant_owner", owner, 1'b0);
    hold = 1'b1; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'd5;
    wait_for(1, 20, n);
    check("hold_fetch_ack", if_ack, 1'b1);
    check("hold_fetch_lat", n, W + 1);
    check("hold_fetch_rdata", if_rdata, 32'h0BADF00D);
    if_addr = 10'd0;
    cnt = 0;
    repeat (8) begin
      @(negedge clk1);
      if (mem_en) cnt++;
    end
    check("hold_no_grant", cnt, 0);
    hold = 1'b0;
    wait_for(0, 10, n);
    check("hold_release_lat", n, 1);
    check("hold_release_owner", owner, 1'b1);
    if_req = 1'b0; dm_req = 1'b0;
    repeat (W + 3) @(negedge clk1);

    // ---------------- reset in the middle of an access ----------------
    do_reset();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'h010;
    wait_for(1, 20, n);
    dm_req = 1'b0;
    check("rstmid_pre_rdata", dm_rdata, 32'h0BADF00D);
    repeat (2) @(negedge clk1);
    dm_req = 1'b1; dm_addr = 10'h2AA;
    wait_for(0, 10, n);
    @(negedge clk1);
    check("rstmid_busy", busy, 1'b1);
    #1 rst = 1'b1;
    #1 check("rstmid_async_zero", {if_rdata, dm_rdata, if_ack, dm_ack, mem_en, mem_we,
                                   mem_addr, mem_wdata, busy, owner}, '0);
    dm_req = 1'b0;
    @(negedge clk1);
    rst = 1'b0;
    cnt = 0;
    repeat (W + 3) begin
      @(negedge clk1);
      if (if_ack || dm_ack) cnt++;
    end
    check("rstmid_no_ack", cnt, 0);
    if_req = 1'b1; if_addr = 10'd5;
    wait_for(0, 10, n);
    check("rstmid_new_grant_lat", n, 1);
    wait_for(1, 20, n);
    check("rstmid_new_ack_lat", n, W + 1);
    check("rstmid_new_rdata", if_rdata, 32'hDEADBEEF);
    if_req = 1'b0;
    repeat (2) @(negedge clk1);

    // ---------------- randomised run against the timeline model ----------------
    do_reset();
    cyc = 0; g = -100; free_edge = 0; starve = 0; who = 1'b0; gwe = 1'b0;
    gaddr = '0; gwdata = '0; exp_if = '0; exp_dm = '0;
    seen_if = 1'b0; seen_dm = 1'b0;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(10'(i));
    for (int c = 0; c < 2500; c++) begin
      // A request stays up until its ack; afterwards it is re-rolled.
      if (!if_req || seen_if) if_req = ($urandom_range(0, 2) != 0);
      if (!dm_req || seen_dm) dm_req = ($urandom_range(0, 2) != 0);
      if_addr  = 10'($urandom_range(0, 63));
      dm_addr  = 10'($urandom_range(0, 63));
      dm_we    = 1'($urandom_range(0, 1));
      dm_wdata = $urandom();
      hold     = ($urandom_range(0, 4) == 0);

      // The coming edge: a grant needs the port free for W+3 edges since the last one.
      cyc++;
      if (cyc >= free_edge && !hold && (if_req || dm_req)) begin
        dwin   = dm_req && !(if_req && starve == SM);
        g      = cyc;
        who    = dwin;
        gaddr  = dwin ? dm_addr : if_addr;
        gwe    = dwin && dm_we;
        gwdata = dm_wdata;
        if (!dwin) starve = 0;
        else if (if_req && starve < SM) starve++;
        free_edge = cyc + W + 3;
        if (gwe) ref_mem[gaddr[5:0]] = gwdata;
      end
      if (cyc == g + W + 1) begin
        if (!who) exp_if = ref_mem[gaddr[5:0]];
        else if (!gwe) exp_dm = ref_mem[gaddr[5:0]];
      end

      @(negedge clk1);
      check("rnd_mem_en", mem_en, cyc == g);
      if (cyc == g) begin
        check("rnd_mem_addr", mem_addr, gaddr);
        check("rnd_mem_we", mem_we, gwe);
        if (gwe) check("rnd_mem_wdata", mem_wdata, gwdata);
      end
      check("rnd_if_ack", if_ack, (cyc == g + W + 1) && !who);
      check("rnd_dm_ack", dm_ack, (cyc == g + W + 1) && who);
      check("rnd_busy", busy, (cyc >= g) && (cyc <= g + W + 1));
      check("rnd_owner", owner, who);
      check("rnd_if_rdata", if_rdata, exp_if);
      check("rnd_dm_rdata", dm_rdata, exp_dm);
      seen_if = if_ack;
      seen_dm = dm_ack;
    end
    idle_inputs();
    repeat (W + 4) @(negedge clk1);

    check("ack_exclusive", both_ack, 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the processor's single-port 1024 x 32 unified memory between two requesters: the instruction-fetch path and the data path (LW/SW). It serialises accesses, inserts a programmable memory wait, returns read data with a one-cycle acknowledge, and guarantees fetch forward progress with a starvation counter. It sits between the pipeline's fetch/memory stages and the memory array. It turns the current implicit dual access into a sequenced, single-port resource.

## Interface
Parameters:
- ADDR_W, 10, memory word-address width (1024 words)
- DATA_W, 32, data width
- WAIT_CYCLES, 1, memory read latency in edges after the edge that samples mem_en (legal 1..15)
- STARVE_MAX, 4, consecutive data grants allowed while fetch waits (legal 1..15)

Ports:
- clk1  in  1  single clock, all logic on posedge
- rst  in  1  asynchronous, active-high reset
- hold  in  1  1 = no new grants (pipeline halted); in-flight access completes
- if_req  in  1  fetch request, held until if_ack
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched word, registered
- if_ack  out  1  one-cycle fetch completion pulse
- dm_req  in  1  data request, held until dm_ack
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_rdata  out  DATA_W  loaded word, registered
- dm_ack  out  1  one-cycle data completion pulse
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable, valid with mem_en
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  state != IDLE
- owner  out  1  current/last grant: 0 = fetch, 1 = data

## Operation
- FSM: IDLE, ACCESS, DONE. All outputs are registered.
- IDLE: if hold=0 and any req is high, grant, latch addr/we/wdata into mem_* regs, set owner, enter ACCESS, and clear wait counter. Otherwise stay.
- Priority: data wins a tie unless starve_cnt == STARVE_MAX, in which case fetch wins. A lone requester always wins.
- starve_cnt: increments (saturating at STARVE_MAX) on each data grant made while if_req=1. Clears to 0 on any fetch grant.
- ACCESS: mem_en=1 (and mem_we=dm_we for a data grant, 0 for fetch) in the first ACCESS cycle only. The wait counter increments each edge. At the edge where the counter == WAIT_CYCLES, capture mem_rdata into the owner's rdata reg (loads and fetches only; stores leave dm_rdata unchanged) and enter DONE.
- DONE: the owner's ack=1 for exactly this cycle. Requests are ignored. The next state is always IDLE.
- Requests are sampled only in IDLE. Address/data changes while not in IDLE are ignored.
- hold=1 in ACCESS/DONE does not abort. hold only blocks the IDLE->ACCESS transition.
- Reset (asynchronous, any state): state=IDLE, mem_en=mem_we=0, mem_addr=mem_wdata=0, if_rdata=dm_rdata=0, if_ack=dm_ack=0, busy=0, owner=0, starve_cnt=0, wait counter=0. An aborted access produces no ack. A store whose mem_en edge already passed is not rolled back.

## Timing
- Request sampled high at edge E0 (IDLE): ACCESS from E0, mem_en high during cycle E0..E1, memory samples at E1, rdata captured at E0+WAIT_CYCLES+1, ack high during the following cycle.
- Request-to-ack latency: WAIT_CYCLES+1 cycles. Per-access occupancy: WAIT_CYCLES+3 cycles (IDLE, ACCESS x (WAIT_CYCLES+1), DONE).
- The requester deasserts or changes req after seeing ack. A req still high in DONE is not regranted until IDLE samples it.
- if_ack and dm_ack are never high in the same cycle. mem_en is never high outside the first ACCESS cycle.

## Test plan
- Reset: assert rst mid-run -> every output 0 immediately (asynchronous), state IDLE, busy=0.
- Single fetch, WAIT_CYCLES=1: if_req, if_addr=5, memory returns 0xDEADBEEF -> mem_en one cycle with mem_addr=5, mem_we=0. if_ack one-cycle pulse 2 cycles after the grant edge. if_rdata=0xDEADBEEF.
- Tie then store: if_req and dm_req (dm_we=1, dm_addr=0x3FF, dm_wdata=0x12345678) in the same cycle -> data granted first with mem_we=1, mem_addr=0x3FF, mem_wdata=0x12345678. dm_ack pulses and dm_rdata is unchanged. Fetch is granted next, exactly WAIT_CYCLES+3 cycles after the first grant.
- Starvation, STARVE_MAX=4: dm_req and if_req held high continuously -> grant sequence D,D,D,D,F,D,D,D,D,F. owner toggles accordingly.
- hold: assert hold during a fetch ACCESS -> that fetch still acks. With both reqs pending, no mem_en while hold=1. The first grant occurs at the first IDLE edge after hold=0.
- Reset mid-access (WAIT_CYCLES=3, rst in 2nd ACCESS cycle) -> no ack ever issued for that access. After release, a new if_req completes normally in WAIT_CYCLES+1 cycles.
